// File: rtl/mem_ctrl.sv
// Word-addressed memory controller with programmable wait states.
// Define MEM_PARITY_EN to store and check an even-parity bit per word.
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  MEM_clock,
    input  logic                  MEM_reset,
    input  logic [ADDR_WIDTH-1:0] MEM_addr_in,
    input  logic [DATA_WIDTH-1:0] MEM_data_in,
    input  logic                  MEM_read_req,
    input  logic                  MEM_write_req,
    input  logic                  MEM_parity_flip,
    output logic [DATA_WIDTH-1:0] MEM_data_out,
    output logic                  MEM_busy,
    output logic                  MEM_done,
    output logic                  MEM_error,
    output logic                  MEM_parity_err
);

`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    wr_op_q, wr_op_d;
    logic                    flip_q, flip_d;
    logic                    err_q, err_d;
    logic                    perr_q, perr_d;

    logic [WORD_W-1:0]       mem_array [DEPTH];
    logic [WORD_W-1:0]       rd_word;
    logic [WORD_W-1:0]       wr_word;
    logic                    mem_we;
    logic                    parity_bad;
    logic                    both_req;
    logic                    one_req;

    assign both_req = MEM_read_req & MEM_write_req;
    assign one_req  = MEM_read_req ^ MEM_write_req;
    assign rd_word  = mem_array[addr_q];

`ifdef MEM_PARITY_EN
    assign wr_word    = {(^wdata_q) ^ flip_q, wdata_q};
    assign parity_bad = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];
`else
    logic unused_flip;
    assign unused_flip = flip_q;
    assign wr_word     = wdata_q;
    assign parity_bad  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_op_d = wr_op_q;
        flip_d  = flip_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
        perr_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (both_req) begin
                    err_d = 1'b1;
                end else if (one_req) begin
                    addr_d  = MEM_addr_in;
                    wdata_d = MEM_data_in;
                    wr_op_d = MEM_write_req;
                    flip_d  = MEM_parity_flip;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // leave on the 1 -> 0 edge; <= also covers a stray zero
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wr_op_q) begin
                    mem_we = 1'b1;
                end else begin
                    dout_d = rd_word[DATA_WIDTH-1:0];
                    perr_d = parity_bad;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge MEM_clock) begin
        if (MEM_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_op_q <= 1'b0;
            flip_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_op_q <= wr_op_d;
            flip_q  <= flip_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
        end
    end

    // array is never cleared; reset only blocks a pending write
    always_ff @(posedge MEM_clock) begin
        if (mem_we && !MEM_reset) begin
            mem_array[addr_q] <= wr_word;
        end
    end

    assign MEM_busy       = (state_q != S_IDLE);
    assign MEM_done       = (state_q == S_DONE);
    assign MEM_data_out   = dout_q;
    assign MEM_error      = err_q;
    assign MEM_parity_err = perr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model checked every cycle
// plus directed operations with literal expectations.
module tb_mem_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int WS = 2;
`ifdef MEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rd;
    logic          wr;
    logic          flip;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;
    logic          err;
    logic          perr;

    always #5 clk = ~clk;

    mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS)
    ) dut (
        .MEM_clock      (clk),
        .MEM_reset      (rst),
        .MEM_addr_in    (addr),
        .MEM_data_in    (din),
        .MEM_read_req   (rd),
        .MEM_write_req  (wr),
        .MEM_parity_flip(flip),
        .MEM_data_out   (dout),
        .MEM_busy       (busy),
        .MEM_done       (done),
        .MEM_error      (err),
        .MEM_parity_err (perr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // inputs as seen by the most recent rising edge
    logic          s_rst, s_rd, s_wr, s_flip;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;

    always @(posedge clk) begin
        s_rst  <= rst;
        s_rd   <= rd;
        s_wr   <= wr;
        s_flip <= flip;
        s_addr <= addr;
        s_data <= din;
    end

    // model: an accepted op occupies WS+2 cycles, access on the last-but-one
    logic [DW-1:0] m_mem [bit [AW-1:0]];
    bit            m_bad [bit [AW-1:0]];
    bit            m_live = 1'b0;
    bit            m_busy, m_done, m_err, m_perr, m_dknown, m_w, m_f;
    int            m_rem;
    bit [AW-1:0]   m_a;
    logic [DW-1:0] m_d, m_dout;

    initial forever begin
        @(negedge clk);
        if (s_rst) begin
            m_live = 1'b1; m_busy = 0; m_rem = 0; m_done = 0;
            m_err = 0; m_perr = 0; m_dout = '0; m_dknown = 1'b1;
        end else if (m_live) begin
            m_done = 0; m_err = 0; m_perr = 0;
            if (!m_busy) begin
                if (s_rd && s_wr) begin
                    m_err = 1'b1;
                end else if (s_rd || s_wr) begin
                    m_busy = 1'b1; m_rem = WS + 2; m_w = s_wr;
                    m_a = s_addr; m_d = s_data; m_f = s_flip;
                end
            end else begin
                m_rem--;
                if (m_rem == 1) begin
                    m_done = 1'b1;
                    if (m_w) begin
                        m_mem[m_a] = m_d;
                        m_bad[m_a] = m_f;
                    end else if (m_mem.exists(m_a)) begin
                        m_dout = m_mem[m_a];
                        m_dknown = 1'b1;
                        m_perr = PAR && m_bad[m_a];
                    end else begin
                        m_dknown = 1'b0;
                    end
                end
                if (m_rem == 0) m_busy = 1'b0;
            end
        end
        if (m_live) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_error", err, m_err);
            chk("cyc_perr", perr, m_perr);
            if (m_dknown) chk("cyc_dout", dout, m_dout);
        end
    end

    task automatic run_op(input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit f,
                          output int busy_n, output int done_at,
                          output logic [DW-1:0] dq, output logic pq);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; din = d; flip = f;
        @(posedge clk); #1;
        rd = 0; wr = 0; addr = ~a; din = ~d; flip = ~f;
        busy_n = 0; done_at = -1; dq = 'x; pq = 1'bx;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_n++;
            if (done) begin
                done_at = i; dq = dout; pq = perr;
            end
            if (!busy) break;
        end
    endtask

    int            bn, da, dn;
    logic [DW-1:0] dq;
    logic          pq;

    initial begin
        rst = 1; rd = 0; wr = 0; flip = 0; addr = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", err, 0);
        chk("rst_dout", dout, 0);
        chk("rst_perr", perr, 0);
        rst = 0;

        run_op(0, 1, 8'h10, 16'hBEEF, 0, bn, da, dq, pq);
        chk("wr_busy_cycles", bn, 4);
        chk("wr_done_edge", da, 3);
        chk("wr_dout_held", dq, 16'h0000);

        run_op(1, 0, 8'h10, 16'h0000, 0, bn, da, dq, pq);
        chk("rd_busy_cycles", bn, 4);
        chk("rd_done_edge", da, 3);
        chk("rd_data", dq, 16'hBEEF);
        chk("rd_perr", pq, 0);

        @(posedge clk); #1;
        rd = 1; wr = 1; addr = 8'h10; din = 16'h5555;
        @(posedge clk); #1;
        chk("both_error", err, 1);
        chk("both_busy", busy, 0);
        rd = 0; wr = 0;
        @(posedge clk); #1;
        chk("both_error_clr", err, 0);
        chk("both_no_done", done, 0);
        run_op(1, 0, 8'h10, 16'h0000, 0, bn, da, dq, pq);
        chk("both_rd_data", dq, 16'hBEEF);

        run_op(0, 1, 8'h20, 16'h0000, 0, bn, da, dq, pq);
        @(posedge clk); #1;
        wr = 1; addr = 8'h20; din = 16'h1234;
        @(posedge clk); #1;
        wr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dout", dout, 16'h0000);
        chk("abort_error", err, 0);
        chk("abort_perr", perr, 0);
        rst = 0;
        run_op(1, 0, 8'h20, 16'h0000, 0, bn, da, dq, pq);
        chk("abort_rd_data", dq, 16'h0000);
        chk("abort_not_1234", (dq == 16'h1234), 0);

        run_op(0, 1, 8'h40, 16'hAAAA, 0, bn, da, dq, pq);
        dn = (da >= 0) ? 1 : 0;
        chk("busy_ign_first", dn, 1);
        @(posedge clk); #1;
        wr = 1; addr = 8'h41; din = 16'h7777;
        @(posedge clk); #1;
        wr = 0; rd = 1; addr = 8'h10;
        dn = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
            if (i == 3) rd = 0;
        end
        chk("busy_ign_dones", dn, 1);
        chk("busy_ign_dout", dout, 16'h0000);
        run_op(1, 0, 8'h10, 16'h0000, 0, bn, da, dq, pq);
        chk("busy_ign_rd10", dq, 16'hBEEF);
        run_op(1, 0, 8'h41, 16'h0000, 0, bn, da, dq, pq);
        chk("busy_ign_rd41", dq, 16'h7777);

        run_op(0, 1, 8'h30, 16'h0001, 1, bn, da, dq, pq);
        run_op(1, 0, 8'h30, 16'h0000, 0, bn, da, dq, pq);
        chk("par_flip_data", dq, 16'h0001);
        chk("par_flip_err", pq, PAR);
        run_op(0, 1, 8'h31, 16'h0007, 0, bn, da, dq, pq);
        run_op(1, 0, 8'h31, 16'h0000, 1, bn, da, dq, pq);
        chk("par_ok_data", dq, 16'h0007);
        chk("par_ok_err", pq, 0);

        run_op(0, 1, 8'hFF, 16'hFFFF, 0, bn, da, dq, pq);
        run_op(1, 0, 8'hFF, 16'h0000, 0, bn, da, dq, pq);
        chk("top_addr_data", dq, 16'hFFFF);
        chk("top_addr_busy", bn, 4);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
